// File: rtl/img_pkg.sv
// Shared frame geometry defaults, coordinate widths and streamer FSM states.
package img_pkg;

  localparam int unsigned DEF_IMG_W = 5;
  localparam int unsigned DEF_IMG_H = 5;
  localparam int unsigned DEF_PXL_W = 8;

  // Number of qualifier bits stored beside each pixel: sof, eol, eof.
  localparam int unsigned FLAG_W = 3;

  function automatic int unsigned coord_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_X_W = coord_w(DEF_IMG_W);
  localparam int unsigned DEF_Y_W = coord_w(DEF_IMG_H);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/frame_out_streamer_if.sv
// Control, frame-buffer read and pixel-stream signals of frame_out_streamer.
interface frame_out_streamer_if
  import img_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned PXL_W = DEF_PXL_W
);
  localparam int unsigned XW = coord_w(IMG_W);
  localparam int unsigned YW = coord_w(IMG_H);

  logic             start;
  logic             busy;
  logic             frame_done;
  logic             rd_en;
  logic [XW-1:0]    rd_x;
  logic [YW-1:0]    rd_y;
  logic [PXL_W-1:0] rd_data_pxl;
  logic             out_valid;
  logic             out_ready;
  logic [PXL_W-1:0] out_pxl;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;

  modport master (
    input  start, rd_data_pxl, out_ready,
    output busy, frame_done, rd_en, rd_x, rd_y,
           out_valid, out_pxl, out_sof, out_eol, out_eof
  );

  modport slave (
    output start, rd_data_pxl, out_ready,
    input  busy, frame_done, rd_en, rd_x, rd_y,
           out_valid, out_pxl, out_sof, out_eol, out_eof
  );

endinterface

// File: rtl/pxl_fifo2.sv
// Two-entry FIFO holding a pixel plus its frame qualifiers; head is presented combinationally.
module pxl_fifo2 #(
  parameter int unsigned DW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/frame_out_streamer.sv
// Reads one frame in raster order from a 1-cycle-latency buffer and streams it with sof/eol/eof.
module frame_out_streamer
  import img_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned PXL_W = DEF_PXL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_out_streamer_if.master bus
);

  localparam int unsigned XW = coord_w(IMG_W);
  localparam int unsigned YW = coord_w(IMG_H);
  localparam int unsigned FW = PXL_W + FLAG_W;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            done_q, done_d;
  logic            infl_q;
  logic            infl_sof_q, infl_eol_q, infl_eof_q;
  logic            rd_en_c;
  logic            pop;
  logic            last_x, last_pix;
  logic [1:0]      occ;
  logic [2:0]      need;
  logic            credit_ok;
  logic            fifo_full, fifo_empty;
  logic [FW-1:0]   fifo_din, fifo_dout;

  assign last_x   = (x_q == XW'(IMG_W - 1));
  assign last_pix = last_x && (y_q == YW'(IMG_H - 1));
  assign pop      = !fifo_empty && bus.out_ready;

  // Credit: stored + in-flight - leaving now must stay below the FIFO depth.
  assign occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign need      = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
  assign credit_ok = (need < 3'd2);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rd_en_c = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_READ;
      end
      ST_READ: begin
        if (credit_ok) begin
          rd_en_c = 1'b1;
          if (last_x) begin
            x_d = '0;
            y_d = last_pix ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (last_pix) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave DRAIN one cycle after the eof handshake so a start beside frame_done is ignored.
        if (pop && fifo_dout[FW-1]) done_d = 1'b1;
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      done_q     <= 1'b0;
      infl_q     <= 1'b0;
      infl_sof_q <= 1'b0;
      infl_eol_q <= 1'b0;
      infl_eof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      infl_q  <= rd_en_c;
      if (rd_en_c) begin
        infl_sof_q <= (x_q == '0) && (y_q == '0);
        infl_eol_q <= last_x;
        infl_eof_q <= last_pix;
      end
    end
  end

  assign fifo_din = {infl_eof_q, infl_eol_q, infl_sof_q, bus.rd_data_pxl};

  pxl_fifo2 #(
    .DW(FW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (infl_q),
    .pop_i  (pop),
    .data_i (fifo_din),
    .data_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = done_q;
  assign bus.rd_en      = rd_en_c;
  assign bus.rd_x       = x_q;
  assign bus.rd_y       = y_q;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_pxl    = fifo_dout[PXL_W-1:0];
  assign bus.out_sof    = fifo_dout[PXL_W];
  assign bus.out_eol    = fifo_dout[PXL_W+1];
  assign bus.out_eof    = fifo_dout[PXL_W+2];

endmodule
